// File: rtl/mips_mc_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips_mc_controller_if                                                      |
// | Bus between the multi-cycle MIPS control unit and its datapath.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface mips_mc_controller_if #(
   parameter int STATE_W = 4
);
   logic [5:0]         op;
   logic [5:0]         funct;
   logic               zero;
   logic               pcen;
   logic               iord;
   logic               memwrite;
   logic               irwrite;
   logic               regdst;
   logic               memtoreg;
   logic               regwrite;
   logic               alusrca;
   logic [1:0]         alusrcb;
   logic [1:0]         pcsrc;
   logic [2:0]         alucontrol;
   logic [STATE_W-1:0] state_dbg;

   // Datapath side
   modport master (
      output op, funct, zero,
      input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
             alusrca, alusrcb, pcsrc, alucontrol, state_dbg
   );

   // Controller side
   modport slave (
      input  op, funct, zero,
      output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
             alusrca, alusrcb, pcsrc, alucontrol, state_dbg
   );
endinterface
`default_nettype wire

// File: rtl/mips_mc_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips_mc_controller                                                         |
// | Multi-cycle MIPS control unit: Moore main FSM plus ALU decoder.            |
// | Optional: `define MC_CTRL_BNE_EN adds the BNEEX state (op 000101).         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mips_mc_controller #(
   parameter int STATE_W = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   mips_mc_controller_if.slave  bus
);

   typedef enum logic [STATE_W-1:0] {
      FETCH   = STATE_W'(0),
      DECODE  = STATE_W'(1),
      MEMADR  = STATE_W'(2),
      MEMRD   = STATE_W'(3),
      MEMWB   = STATE_W'(4),
      MEMWR   = STATE_W'(5),
      RTYPEEX = STATE_W'(6),
      RTYPEWB = STATE_W'(7),
      BEQEX   = STATE_W'(8),
      ADDIEX  = STATE_W'(9),
      ADDIWB  = STATE_W'(10),
`ifdef MC_CTRL_BNE_EN
      JEX     = STATE_W'(11),
      BNEEX   = STATE_W'(12)
`else
      JEX     = STATE_W'(11)
`endif
   } state_t;

   typedef struct packed {
      logic       iord;
      logic       memwrite;
      logic       irwrite;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [2:0] alucontrol;
      logic       pcwrite;
      logic       branch;
      logic       bne;
      logic       rtype;
   } ctrl_t;

   state_t state_q, state_d;
   ctrl_t  ctrl_q;
   ctrl_t  ctrl_out;
   logic   branch_cond;

   function automatic ctrl_t state_outputs(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH:   begin c.alusrcb = 2'b01; c.alucontrol = 3'b010;
                        c.irwrite = 1'b1; c.pcwrite = 1'b1; end
         DECODE:  begin c.alusrcb = 2'b11; c.alucontrol = 3'b010; end
         MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.alucontrol = 3'b010; end
         MEMRD:   c.iord = 1'b1;
         MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
         MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
         RTYPEEX: begin c.alusrca = 1'b1; c.rtype = 1'b1; end
         RTYPEWB: begin c.regdst = 1'b1; c.regwrite = 1'b1; end
         BEQEX:   begin c.alusrca = 1'b1; c.alucontrol = 3'b110;
                        c.pcsrc = 2'b01; c.branch = 1'b1; end
         ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.alucontrol = 3'b010; end
         ADDIWB:  c.regwrite = 1'b1;
         JEX:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
`ifdef MC_CTRL_BNE_EN
         BNEEX:   begin c.alusrca = 1'b1; c.alucontrol = 3'b110;
                        c.pcsrc = 2'b01; c.branch = 1'b1; c.bne = 1'b1; end
`endif
         default: c = '0;
      endcase
      return c;
   endfunction

   function automatic logic [2:0] funct_alu(input logic [5:0] f);
      case (f)
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:   state_d = DECODE;
         DECODE: begin
            case (bus.op)
               6'b100011, 6'b101011: state_d = MEMADR;
               6'b000000:            state_d = RTYPEEX;
               6'b000100:            state_d = BEQEX;
               6'b001000:            state_d = ADDIEX;
               6'b000010:            state_d = JEX;
`ifdef MC_CTRL_BNE_EN
               6'b000101:            state_d = BNEEX;
`endif
               default:              state_d = FETCH;
            endcase
         end
         MEMADR:  state_d = (bus.op == 6'b100011) ? MEMRD : MEMWR;
         MEMRD:   state_d = MEMWB;
         RTYPEEX: state_d = RTYPEWB;
         ADDIEX:  state_d = ADDIWB;
         default: state_d = FETCH;
      endcase
   end

   // Outputs are registered alongside the state they belong to.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= FETCH;
         ctrl_q  <= state_outputs(FETCH);
      end else begin
         state_q <= state_d;
         ctrl_q  <= state_outputs(state_d);
      end
   end

   // While reset is held the bus shows FETCH values with every enable off.
   always_comb begin
      ctrl_out = ctrl_q;
      if (!reset) begin
         ctrl_out          = state_outputs(FETCH);
         ctrl_out.irwrite  = 1'b0;
         ctrl_out.pcwrite  = 1'b0;
         ctrl_out.memwrite = 1'b0;
         ctrl_out.regwrite = 1'b0;
         ctrl_out.branch   = 1'b0;
      end
   end

`ifdef MC_CTRL_BNE_EN
   assign branch_cond = ctrl_out.bne ? ~bus.zero : bus.zero;
`else
   assign branch_cond = bus.zero;
`endif

   assign bus.pcen       = ctrl_out.pcwrite | (ctrl_out.branch & branch_cond);
   assign bus.iord       = ctrl_out.iord;
   assign bus.memwrite   = ctrl_out.memwrite;
   assign bus.irwrite    = ctrl_out.irwrite;
   assign bus.regdst     = ctrl_out.regdst;
   assign bus.memtoreg   = ctrl_out.memtoreg;
   assign bus.regwrite   = ctrl_out.regwrite;
   assign bus.alusrca    = ctrl_out.alusrca;
   assign bus.alusrcb    = ctrl_out.alusrcb;
   assign bus.pcsrc      = ctrl_out.pcsrc;
   assign bus.alucontrol = ctrl_out.rtype ? funct_alu(bus.funct) : ctrl_out.alucontrol;
   assign bus.state_dbg  = state_q;

endmodule
`default_nettype wire

// File: doc/mips_mc_controller.md
Name: mips_mc_controller

Overview:
- Multi-cycle MIPS control unit: Moore main FSM plus ALU decoder.
- Sits directly upstream of the ALU and drives its 3-bit function select `alucontrol`.
- Also sequences PC, IR, memory and register-file enables, and the datapath muxes, across the multi-cycle instruction flow.
- Consumes `op`/`funct` from the instruction register and `zero` from the ALU.

Parameters:
- STATE_W, 4, width of the state register and of the `state_dbg` output.

Ports:
- clk  input  1  clock, all state updates on posedge
- reset  input  1  reset, synchronous, active-low
- op  input  6  instruction[31:26], sampled in DECODE
- funct  input  6  instruction[5:0], used by the ALU decoder
- zero  input  1  ALU zero flag, used in branch states
- pcen  output  1  PC write enable, equal to pcwrite | (branch & zero)
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  output  1  data memory write enable
- irwrite  output  1  instruction register load enable
- regdst  output  1  write register select: 0 = rt, 1 = rd
- memtoreg  output  1  write data select: 0 = ALUOut, 1 = MDR
- regwrite  output  1  register file write enable
- alusrca  output  1  ALU A select: 0 = PC, 1 = register A
- alusrcb  output  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- pcsrc  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  output  3  ALU function select
- state_dbg  output  STATE_W  current state encoding

Behaviour:
- reset==0 at posedge: state <= FETCH (0).
- While reset==0, pcen, memwrite, irwrite and regwrite are forced to 0. All other outputs take FETCH values.
- Outputs are a combinational function of state only (Moore). The one exception is pcen, which also depends on zero.
- Default for every output not listed in a state is 0.
- State encodings and the outputs asserted in each:
  - FETCH 0: iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00, irwrite=1, pcwrite=1. Next: DECODE.
  - DECODE 1: alusrca=0, alusrcb=11, alucontrol=010.
    - Next by op: 100011 lw or 101011 sw -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX; 001000 -> ADDIEX; 000010 -> JEX.
    - Any other op -> FETCH (instruction behaves as a NOP).
  - MEMADR 2: alusrca=1, alusrcb=10, alucontrol=010. Next: MEMRD if op==100011, else MEMWR.
  - MEMRD 3: iord=1. Next: MEMWB.
  - MEMWB 4: regdst=0, memtoreg=1, regwrite=1. Next: FETCH.
  - MEMWR 5: iord=1, memwrite=1. Next: FETCH.
  - RTYPEEX 6: alusrca=1, alusrcb=00, alucontrol=funct decode. Next: RTYPEWB.
  - RTYPEWB 7: regdst=1, memtoreg=0, regwrite=1. Next: FETCH.
  - BEQEX 8: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, branch=1. Next: FETCH.
  - ADDIEX 9: alusrca=1, alusrcb=10, alucontrol=010. Next: ADDIWB.
  - ADDIWB 10: regdst=0, memtoreg=0, regwrite=1. Next: FETCH.
  - JEX 11: pcsrc=10, pcwrite=1. Next: FETCH.
- funct decode (RTYPEEX only):
  - 100000 -> 010 (add)
  - 100010 -> 110 (sub)
  - 100100 -> 000 (and)
  - 100101 -> 001 (or)
  - 101010 -> 111 (slt)
  - any other funct -> 010 (add)
- Cycles per instruction, counted from FETCH entry to the next FETCH:
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; unknown op 2.
- Any undefined state encoding -> FETCH on the next posedge.
- Reset asserted mid-instruction: the FSM returns to FETCH on that edge. No write enable may be asserted during the reset cycle.

Optional Feature:
- Macro: MC_CTRL_BNE_EN.
- Defined:
  - Adds state BNEEX 12, entered from DECODE when op==000101.
  - BNEEX outputs match BEQEX, except pcen = ~zero; next state is FETCH.
- Undefined: op 000101 is treated as unknown (DECODE -> FETCH). Encoding 12 is unused and falls back to FETCH.

Test Plan:
- lw (op=100011) after reset release -> state sequence 0,1,2,3,4,0.
  - irwrite=1 only in state 0; regwrite=1 and memtoreg=1 only in state 4.
- R-type sub (op=000000, funct=100010) -> states 0,1,6,7,0.
  - alucontrol=110 in state 6; regdst=1 and regwrite=1 in state 7.
- beq (op=000100), zero=1 -> pcen=1 in state 8 with pcsrc=01.
  - Repeat with zero=0 -> pcen=0 in state 8.
- j (op=000010) -> states 0,1,11,0; pcen=1 and pcsrc=10 in state 11.
- Unknown op=111111 -> states 0,1,0 with no regwrite or memwrite.
  - With MC_CTRL_BNE_EN: op=000101 and zero=0 -> state 12 with pcen=1.
- Drive reset=0 while in state 3 (lw) -> state 0 at the next edge.
  - memwrite, regwrite, irwrite and pcen all 0 during the reset cycle.
